axis_width_down: RTL and testbench

//  AXI-Stream receiver-side width converter: terminates a wide AXIS stream (Receiver role) and
//  re-emits it as a byte-wide AXIS stream (Transmitter role), skipping null bytes (tkeep=0).

---
 rtl/axis_pkg.sv | 30 +++
 rtl/axis_keep_scan.sv | 27 ++
 rtl/axis_width_down.sv | 123 ++++++++++++
 tb/tb_axis_width_down.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers used by the width converters.
// Byte-lane search over a tkeep vector of up to MAX_BYTES lanes.
package axis_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 64;
  localparam int IDX_W     = 7;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } keep_hit_t;

  // Lowest set keep lane at or above 'from'.
  function automatic keep_hit_t keep_lowest(
    input logic [MAX_BYTES-1:0] keep,
    input logic [IDX_W-1:0]     from
  );
    keep_hit_t r;
    r = '0;
    for (int i = MAX_BYTES - 1; i >= 0; i--) begin
      if (keep[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.index = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_keep_scan.sv
// Finds the next kept byte lane above the current pointer.
// last_byte_o is high when no kept lane remains above ptr_i.
module axis_keep_scan
  import axis_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int PTR_W = 2
) (
  input  logic [BYTES-1:0] keep_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] nxt_o,
  output logic             last_byte_o
);

  logic [MAX_BYTES-1:0] keep_ext;
  logic [IDX_W-1:0]     from;
  keep_hit_t            hit;

  assign keep_ext = MAX_BYTES'(keep_i);
  assign from     = IDX_W'(ptr_i) + IDX_W'(1);
  assign hit      = keep_lowest(keep_ext, from);

  assign last_byte_o = !hit.found ||
                       (hit.index >= IDX_W'(BYTES));
  assign nxt_o       = hit.index[PTR_W-1:0];

endmodule

// File: rtl/axis_width_down.sv
// Wide-to-byte AXI-Stream converter with a one-beat holding register.
// Null bytes are skipped; an all-null tlast beat raises drop_err.
module axis_width_down
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                     drop_err
);

  localparam int BYTES = TDATA_WIDTH / BYTE_W;
  localparam int PTR_W = $clog2(BYTES);

  logic                   full_q, full_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [BYTES-1:0]       keep_q, keep_d;
  logic                   last_q, last_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   drop_q, drop_d;

  logic [PTR_W-1:0] nxt;
  logic             last_byte;
  keep_hit_t        first_hit;
  logic             keep_any;
  logic             acc;
  logic             xfer;
  logic [7:0]       byte_sel;

  axis_keep_scan #(
    .BYTES (BYTES),
    .PTR_W (PTR_W)
  ) u_scan (
    .keep_i      (keep_q),
    .ptr_i       (ptr_q),
    .nxt_o       (nxt),
    .last_byte_o (last_byte)
  );

  assign first_hit = keep_lowest(MAX_BYTES'(s_axis_tkeep), '0);
  assign keep_any  = first_hit.found &&
                     (first_hit.index < IDX_W'(BYTES));

  assign s_axis_tready = !rst &&
                         (!full_q || (m_axis_tready && last_byte));
  assign acc  = s_axis_tvalid && s_axis_tready;
  assign xfer = full_q && m_axis_tready;

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (ptr_q == PTR_W'(i)) byte_sel = data_q[i*BYTE_W +: BYTE_W];
    end
  end

  assign m_axis_tvalid = full_q;
  assign m_axis_tdata  = byte_sel;
  assign m_axis_tlast  = full_q && last_byte && last_q;
  assign m_axis_tuser  = m_axis_tlast ? user_q : '0;
  assign drop_err      = drop_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    user_d = user_q;
    ptr_d  = ptr_q;
    drop_d = 1'b0;
    if (xfer) begin
      if (last_byte) full_d = 1'b0;
      else           ptr_d  = nxt;
    end
    // A reload here overrides the drain above: no bubble between beats.
    if (acc) begin
      if (keep_any) begin
        full_d = 1'b1;
        data_d = s_axis_tdata;
        keep_d = s_axis_tkeep;
        last_d = s_axis_tlast;
        user_d = s_axis_tuser;
        ptr_d  = first_hit.index[PTR_W-1:0];
      end else begin
        drop_d = s_axis_tlast;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      user_q <= '0;
      ptr_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      user_q <= user_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
// Randomized bench for axis_width_down against a byte-queue model.
// Inputs driven on the falling edge, outputs checked 1ns later.
module tb_axis_width_down;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic        drop_err;

  always #5 clk = ~clk;

  axis_width_down #(
    .TDATA_WIDTH (32),
    .TUSER_WIDTH (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .drop_err      (drop_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  typedef struct packed {
    logic       l;
    logic       u;
    logic [7:0] d;
  } ob_t;

  beat_t src[$];
  ob_t   exp_q[$];

  int   vec = 0;
  int   errs = 0;
  int   ready_pct = 100;
  int   valid_pct = 100;
  logic acc_pend = 1'b0;
  logic drop_exp = 1'b0;
  logic stall_prev = 1'b0;
  ob_t  stall_val;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_push(input beat_t b);
    int n = 0;
    ob_t o;
    for (int i = 0; i < 4; i++) begin
      if (b.k[i]) begin
        o.d = b.d[i*8 +: 8];
        o.l = 1'b0;
        o.u = 1'b0;
        exp_q.push_back(o);
        n++;
      end
    end
    if (n != 0 && b.l) begin
      o = exp_q[exp_q.size()-1];
      o.l = 1'b1;
      o.u = b.u;
      exp_q[exp_q.size()-1] = o;
    end
  endtask

  task automatic step();
    int   qs;
    logic rdy_exp;
    ob_t  o;
    @(negedge clk);
    if (acc_pend) s_tvalid = 1'b0;
    acc_pend = 1'b0;
    if (!s_tvalid && src.size() != 0 &&
        $urandom_range(99) < valid_pct) begin
      beat_t b = src.pop_front();
      s_tvalid = 1'b1;
      s_tdata  = b.d;
      s_tkeep  = b.k;
      s_tlast  = b.l;
      s_tuser  = b.u;
    end
    m_tready = ($urandom_range(99) < ready_pct);
    #1;
    qs = exp_q.size();
    rdy_exp = (qs == 0) || (qs == 1 && m_tready);
    chk("m_tvalid", 32'(m_tvalid), 32'(qs != 0));
    chk("s_tready", 32'(s_tready), 32'(rdy_exp));
    chk("drop_err", 32'(drop_err), 32'(drop_exp));
    if (stall_prev && m_tvalid)
      chk("stall_hold", 32'({m_tlast, m_tuser, m_tdata}), 32'(stall_val));
    if (m_tvalid && m_tready && qs != 0) begin
      o = exp_q.pop_front();
      chk("byte", 32'({m_tlast, m_tuser, m_tdata}), 32'(o));
    end
    stall_prev = m_tvalid && !m_tready;
    stall_val  = {m_tlast, m_tuser, m_tdata};
    drop_exp = 1'b0;
    if (s_tvalid && s_tready) begin
      beat_t b;
      b.d = s_tdata;
      b.k = s_tkeep;
      b.l = s_tlast;
      b.u = s_tuser;
      acc_pend = 1'b1;
      model_push(b);
      drop_exp = (s_tkeep == 4'h0) && s_tlast;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((src.size() != 0 || s_tvalid || exp_q.size() != 0) &&
           n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    s_tvalid = 1'b0;
    src.delete();
    exp_q.delete();
    acc_pend   = 1'b0;
    drop_exp   = 1'b0;
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    rst = 1'b0;
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    b.u = u;
    return b;
  endfunction

  initial begin
    int n;
    do_reset();

    // single full beat
    src.push_back(mk(32'h44332211, 4'hF, 1'b1, 1'b1));
    drain();

    // back-to-back full beats
    for (int i = 0; i < 3; i++)
      src.push_back(mk($urandom, 4'hF, i == 2, 1'b1));
    drain();

    // sparse keep
    src.push_back(mk(32'hDDCCBBAA, 4'b1010, 1'b1, 1'b1));
    drain();

    // 100-byte frame with random sink stalls
    ready_pct = 50;
    for (int i = 0; i < 25; i++)
      src.push_back(mk($urandom, 4'hF, i == 24, 1'b1));
    drain();
    ready_pct = 100;

    // null beats
    src.push_back(mk($urandom, 4'h0, 1'b1, 1'b1));
    src.push_back(mk($urandom, 4'h0, 1'b0, 1'b1));
    src.push_back(mk(32'h0, 4'h0, 1'b1, 1'b0));
    drain();

    // reset after two of four bytes
    src.push_back(mk(32'h87654321, 4'hF, 1'b1, 1'b1));
    n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 2 && acc_pend == 1'b0 && !s_tvalid) &&
               n < 50);
    if (n >= 50) chk("mid_timeout", 32'd1, 32'd0);
    do_reset();
    src.push_back(mk(32'hA4A3A2A1, 4'hF, 1'b1, 1'b0));
    drain();

    // fully random traffic
    valid_pct = 70;
    ready_pct = 60;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] k = 4'($urandom_range(15));
      if ($urandom_range(3) != 0 && k == 4'h0) k = 4'hF;
      src.push_back(mk($urandom, k, ($urandom_range(3) == 0),
                       1'($urandom)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
